gd_audio_sample_fifo: RTL and testbench

Stereo sample buffer feeding the digital audio output stage. The host pushes 16-bit signed left/right sample pairs through a valid/ready port; the block releases exactly one pair per 64-clock audio frame, time-aligned to the shared `soundcounter` so the output stage sees a stable `sample_l`/`sample_r` when it latches at phase 63. It provides underrun detection and, optionally, per-channel volume scaling.

---
 rtl/gd_audio_sample_fifo_if.sv | 10 +
 rtl/gd_audio_sample_fifo.sv | 100 ++++++++++
 tb/tb_gd_audio_sample_fifo.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gd_audio_sample_fifo_if.sv
// rtl/gd_audio_sample_fifo_if.sv - host push port (valid/ready) carrying one stereo sample pair.
interface gd_audio_sample_fifo_if;
  logic               wr_valid;
  logic               wr_ready;
  logic signed [15:0] wr_left;
  logic signed [15:0] wr_right;

  modport master (output wr_valid, output wr_left, output wr_right, input wr_ready);
  modport slave  (input wr_valid, input wr_left, input wr_right, output wr_ready);
endinterface

// File: rtl/gd_audio_sample_fifo.sv
// rtl/gd_audio_sample_fifo.sv - stereo sample FIFO releasing one pair per 64-clock frame.
// Optional per-channel volume scaling when GD_AUDIO_VOLUME_EN is defined.
module gd_audio_sample_fifo #(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                     vga_clk,
  input  logic                     reset_n,
  input  logic [5:0]               soundcounter,
  gd_audio_sample_fifo_if.slave    wr,
  input  logic [8:0]               vol_l,
  input  logic [8:0]               vol_r,
  output logic signed [15:0]       sample_l,
  output logic signed [15:0]       sample_r,
  output logic [DEPTH_LOG2:0]      level,
  output logic                     underrun,
  input  logic                     underrun_clr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic signed [15:0]    stage_l;
  logic signed [15:0]    stage_r;
  logic signed [15:0]    scaled_l;
  logic signed [15:0]    scaled_r;
  logic                  push;
  logic                  pop_phase;
  logic                  pop;

  assign wr.wr_ready = (level != FULL);
  assign push        = wr.wr_valid && wr.wr_ready;
  assign pop_phase   = (soundcounter == 6'd61);
  // Pop decision uses pre-edge level, so a same-edge push into an empty FIFO still underruns.
  assign pop         = pop_phase && (level != '0);

  always_ff @(posedge vga_clk) begin
    if (push) mem[wr_ptr] <= {wr.wr_left, wr.wr_right};
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      stage_l  <= '0;
      stage_r  <= '0;
      sample_l <= '0;
      sample_r <= '0;
      underrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr             <= rd_ptr + 1'b1;
        {stage_l, stage_r} <= mem[rd_ptr];
      end else if (pop_phase) begin
        stage_l <= '0;
        stage_r <= '0;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
      if (pop_phase && !pop)  underrun <= 1'b1;
      else if (underrun_clr)  underrun <= 1'b0;
      if (soundcounter == 6'd62) begin
        sample_l <= scaled_l;
        sample_r <= scaled_r;
      end
    end
  end

`ifdef GD_AUDIO_VOLUME_EN
  function automatic logic signed [15:0] scale(input logic signed [15:0] s, input logic [8:0] vol);
    logic [8:0]         v;
    logic signed [24:0] s_ext;
    logic signed [24:0] v_ext;
    logic signed [24:0] prod;
    logic signed [24:0] shifted;
    v       = (vol > 9'd256) ? 9'd256 : vol;
    s_ext   = 25'(s);
    v_ext   = {16'd0, v};
    prod    = s_ext * v_ext;
    shifted = prod >>> 8;
    return shifted[15:0];
  endfunction

  assign scaled_l = scale(stage_l, vol_l);
  assign scaled_r = scale(stage_r, vol_r);
`else
  logic unused_vol;
  assign unused_vol = ^{vol_l, vol_r};
  assign scaled_l   = stage_l;
  assign scaled_r   = stage_r;
`endif

endmodule

// File: tb/tb_gd_audio_sample_fifo.sv
// tb/tb_gd_audio_sample_fifo.sv - randomized self-checking bench against a queue-based frame model.
module tb_gd_audio_sample_fifo;

  logic               clk;
  logic               reset_n;
  logic [5:0]         phase;
  logic [8:0]         vol_l;
  logic [8:0]         vol_r;
  logic               underrun_clr;
  logic signed [15:0] sample_l;
  logic signed [15:0] sample_r;
  logic [6:0]         level;
  logic               underrun;

  gd_audio_sample_fifo_if wr_if ();

  gd_audio_sample_fifo #(.DEPTH_LOG2(6)) dut (
    .vga_clk      (clk),
    .reset_n      (reset_n),
    .soundcounter (phase),
    .wr           (wr_if),
    .vol_l        (vol_l),
    .vol_r        (vol_r),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .level        (level),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] mq[$];
  logic [15:0] m_stage_l, m_stage_r, m_out_l, m_out_r;
  logic        m_underrun;
  int          tests;
  int          fails;

`ifdef GD_AUDIO_VOLUME_EN
  function automatic logic [15:0] m_scale(input logic [15:0] s, input logic [8:0] vol);
    int v;
    int p;
    v = (vol > 9'd256) ? 256 : int'(vol);
    p = int'($signed(s)) * v;
    p = p >>> 8;
    return p[15:0];
  endfunction
`endif

  // Advance the frame model by one edge using pre-edge inputs, then clock the DUT.
  task automatic step();
    logic        mp;
    logic [31:0] e;
    if (!reset_n) begin
      mq.delete();
      m_stage_l = 0; m_stage_r = 0; m_out_l = 0; m_out_r = 0; m_underrun = 0;
    end else begin
      mp = wr_if.wr_valid && (mq.size() != 64);
      e  = {wr_if.wr_left, wr_if.wr_right};
      if (phase == 6'd62) begin
`ifdef GD_AUDIO_VOLUME_EN
        m_out_l = m_scale(m_stage_l, vol_l);
        m_out_r = m_scale(m_stage_r, vol_r);
`else
        m_out_l = m_stage_l;
        m_out_r = m_stage_r;
`endif
      end
      if (phase == 6'd61 && mq.size() == 0) begin
        m_stage_l = 0; m_stage_r = 0; m_underrun = 1;
      end else begin
        if (phase == 6'd61) {m_stage_l, m_stage_r} = mq.pop_front();
        if (underrun_clr) m_underrun = 0;
      end
      if (mp) mq.push_back(e);
    end
    @(posedge clk);
    #1;
    phase = phase + 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    wr_if.wr_valid = 0; wr_if.wr_left = 0; wr_if.wr_right = 0;
    underrun_clr = 0; vol_l = 9'd256; vol_r = 9'd256;
    repeat (3) step();
    tests++;
    if ({sample_l, sample_r, level, wr_if.wr_ready, underrun} !== {16'd0, 16'd0, 7'd0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_state got l=%h r=%h lvl=%0d rdy=%b un=%b exp 0 0 0 1 0",
               sample_l, sample_r, level, wr_if.wr_ready, underrun);
    end
    reset_n = 1;
    repeat (3 * 64) begin
      step();
      tests++;
      if ({sample_l, sample_r, level, wr_if.wr_ready, underrun} !==
          {m_out_l, m_out_r, 7'(mq.size()), mq.size() != 64, m_underrun}) begin
        fails++;
        $display("FAIL reset_idle ph=%0d got l=%h r=%h lvl=%0d rdy=%b un=%b exp l=%h r=%h lvl=%0d un=%b",
                 phase, sample_l, sample_r, level, wr_if.wr_ready, underrun,
                 m_out_l, m_out_r, mq.size(), m_underrun);
      end
    end
    tests++;
    if ({underrun, sample_l, sample_r} !== {1'b1, 32'd0}) begin
      fails++;
      $display("FAIL idle_underrun got un=%b l=%h r=%h exp 1 0 0", underrun, sample_l, sample_r);
    end
  endtask

  task automatic test_single();
    int n62;
    vol_l = 9'd256; vol_r = 9'd256;
    underrun_clr = 1; step(); underrun_clr = 0;
    while (phase != 6'd10) step();
    wr_if.wr_valid = 1; wr_if.wr_left = 16'h1234; wr_if.wr_right = 16'hEDCC;
    step();
    wr_if.wr_valid = 0;
    n62 = 0;
    repeat (140) begin
      step();
      tests++;
      if ({sample_l, sample_r, level, wr_if.wr_ready, underrun} !==
          {m_out_l, m_out_r, 7'(mq.size()), mq.size() != 64, m_underrun}) begin
        fails++;
        $display("FAIL single ph=%0d got l=%h r=%h lvl=%0d rdy=%b un=%b exp l=%h r=%h lvl=%0d un=%b",
                 phase, sample_l, sample_r, level, wr_if.wr_ready, underrun,
                 m_out_l, m_out_r, mq.size(), m_underrun);
      end
      if (phase == 6'd63) begin
        n62++;
        tests++;
        if (n62 == 1 && {sample_l, sample_r, underrun} !== {16'h1234, 16'hEDCC, 1'b0}) begin
          fails++;
          $display("FAIL single_out got l=%h r=%h un=%b exp 1234 edcc 0", sample_l, sample_r, underrun);
        end else if (n62 == 2 && {sample_l, sample_r, underrun} !== {32'd0, 1'b1}) begin
          fails++;
          $display("FAIL single_after got l=%h r=%h un=%b exp 0 0 1", sample_l, sample_r, underrun);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int guard;
    while (phase != 6'd0) step();
    guard = 0;
    wr_if.wr_valid = 1;
    while (mq.size() < 64 && guard < 200) begin
      wr_if.wr_left = 16'($urandom); wr_if.wr_right = 16'($urandom);
      step();
      guard++;
    end
    tests++;
    if ({level, wr_if.wr_ready} !== {7'd64, 1'b0}) begin
      fails++;
      $display("FAIL b2b_full got lvl=%0d rdy=%b exp 64 0", level, wr_if.wr_ready);
    end
    while (phase != 6'd61) begin
      step();
      tests++;
      if ({level, wr_if.wr_ready} !== {7'd64, 1'b0}) begin
        fails++;
        $display("FAIL b2b_hold ph=%0d got lvl=%0d rdy=%b exp 64 0", phase, level, wr_if.wr_ready);
      end
    end
    step();
    tests++;
    if ({level, wr_if.wr_ready} !== {7'd63, 1'b1}) begin
      fails++;
      $display("FAIL b2b_pop got lvl=%0d rdy=%b exp 63 1", level, wr_if.wr_ready);
    end
    step();
    wr_if.wr_valid = 0;
    tests++;
    if (level !== 7'd64) begin
      fails++;
      $display("FAIL b2b_refill got lvl=%0d exp 64", level);
    end
    repeat (66 * 64) begin
      step();
      tests++;
      if ({sample_l, sample_r, level, wr_if.wr_ready, underrun} !==
          {m_out_l, m_out_r, 7'(mq.size()), mq.size() != 64, m_underrun}) begin
        fails++;
        $display("FAIL b2b_drain ph=%0d got l=%h r=%h lvl=%0d rdy=%b un=%b exp l=%h r=%h lvl=%0d un=%b",
                 phase, sample_l, sample_r, level, wr_if.wr_ready, underrun,
                 m_out_l, m_out_r, mq.size(), m_underrun);
      end
    end
  endtask

  task automatic test_empty_push61();
    logic [15:0] pl, pr;
    pl = 16'($urandom_range(1, 32767)); pr = 16'($urandom_range(1, 32767));
    vol_l = 9'd256; vol_r = 9'd256;
    underrun_clr = 1; step(); underrun_clr = 0;
    while (phase != 6'd61) step();
    wr_if.wr_valid = 1; wr_if.wr_left = pl; wr_if.wr_right = pr;
    step();
    wr_if.wr_valid = 0;
    step();
    tests++;
    if ({sample_l, sample_r, underrun, level} !== {32'd0, 1'b1, 7'd1}) begin
      fails++;
      $display("FAIL push61_first got l=%h r=%h un=%b lvl=%0d exp 0 0 1 1", sample_l, sample_r, underrun, level);
    end
    repeat (64) begin
      step();
      tests++;
      if ({sample_l, sample_r, level, wr_if.wr_ready, underrun} !==
          {m_out_l, m_out_r, 7'(mq.size()), mq.size() != 64, m_underrun}) begin
        fails++;
        $display("FAIL push61 ph=%0d got l=%h r=%h lvl=%0d un=%b exp l=%h r=%h lvl=%0d un=%b",
                 phase, sample_l, sample_r, level, underrun, m_out_l, m_out_r, mq.size(), m_underrun);
      end
    end
    tests++;
    if ({sample_l, sample_r} !== {pl, pr}) begin
      fails++;
      $display("FAIL push61_next got l=%h r=%h exp l=%h r=%h", sample_l, sample_r, pl, pr);
    end
  endtask

  task automatic test_volume();
    logic [15:0] in_l [3];
    logic [15:0] in_r [3];
    logic [8:0]  v_l  [3];
    logic [8:0]  v_r  [3];
    logic [15:0] ex_l [3];
    logic [15:0] ex_r [3];
    in_l = '{16'h4000, 16'hFFFF, 16'h1234}; in_r = '{16'h7FFF, 16'h8000, 16'h8000};
    v_l  = '{9'd128, 9'd128, 9'd0};         v_r  = '{9'd300, 9'd256, 9'd0};
`ifdef GD_AUDIO_VOLUME_EN
    ex_l = '{16'h2000, 16'hFFFF, 16'h0000}; ex_r = '{16'h7FFF, 16'h8000, 16'h0000};
`else
    ex_l = in_l;                            ex_r = in_r;
`endif
    while (phase != 6'd0) step();
    for (int i = 0; i < 3; i++) begin
      wr_if.wr_valid = 1; wr_if.wr_left = in_l[i]; wr_if.wr_right = in_r[i];
      step();
    end
    wr_if.wr_valid = 0;
    for (int i = 0; i < 3; i++) begin
      vol_l = v_l[i]; vol_r = v_r[i];
      while (phase != 6'd63) step();
      tests++;
      if ({sample_l, sample_r} !== {ex_l[i], ex_r[i]}) begin
        fails++;
        $display("FAIL volume_%0d got l=%h r=%h exp l=%h r=%h", i, sample_l, sample_r, ex_l[i], ex_r[i]);
      end
      step();
    end
    repeat (8 * 64) begin
      wr_if.wr_valid = ($urandom_range(0, 40) == 0);
      wr_if.wr_left = 16'($urandom); wr_if.wr_right = 16'($urandom);
      vol_l = 9'($urandom); vol_r = 9'($urandom);
      step();
      tests++;
      if ({sample_l, sample_r, level, wr_if.wr_ready, underrun} !==
          {m_out_l, m_out_r, 7'(mq.size()), mq.size() != 64, m_underrun}) begin
        fails++;
        $display("FAIL volume_rand ph=%0d got l=%h r=%h lvl=%0d un=%b exp l=%h r=%h lvl=%0d un=%b",
                 phase, sample_l, sample_r, level, underrun, m_out_l, m_out_r, mq.size(), m_underrun);
      end
    end
    wr_if.wr_valid = 0;
  endtask

  task automatic test_random();
    int rate;
    repeat (20) begin
      rate = $urandom_range(0, 80);
      repeat (64) begin
        wr_if.wr_valid = ($urandom_range(0, 80) < rate);
        wr_if.wr_left = 16'($urandom); wr_if.wr_right = 16'($urandom);
        underrun_clr = ($urandom_range(0, 7) == 0);
        vol_l = 9'($urandom); vol_r = 9'($urandom);
        step();
        tests++;
        if ({sample_l, sample_r, level, wr_if.wr_ready, underrun} !==
            {m_out_l, m_out_r, 7'(mq.size()), mq.size() != 64, m_underrun}) begin
          fails++;
          $display("FAIL random ph=%0d got l=%h r=%h lvl=%0d rdy=%b un=%b exp l=%h r=%h lvl=%0d un=%b",
                   phase, sample_l, sample_r, level, wr_if.wr_ready, underrun,
                   m_out_l, m_out_r, mq.size(), m_underrun);
        end
      end
    end
    wr_if.wr_valid = 0; underrun_clr = 0;
  endtask

  task automatic test_reset_mid();
    vol_l = 9'd256; vol_r = 9'd256;
    reset_n = 0; step(); reset_n = 1;
    while (phase != 6'd55) step();
    repeat (6) begin
      wr_if.wr_valid = 1;
      wr_if.wr_left = 16'($urandom_range(1, 32767)); wr_if.wr_right = 16'($urandom_range(1, 32767));
      step();
    end
    wr_if.wr_valid = 0;
    while (phase != 6'd30) step();
    tests++;
    if ({level, sample_l != 16'd0, sample_r != 16'd0} !== {7'd5, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL mid_pre got lvl=%0d l=%h r=%h exp lvl 5 nonzero", level, sample_l, sample_r);
    end
    reset_n = 0;
    #2;
    tests++;
    if ({sample_l, sample_r, level, wr_if.wr_ready, underrun} !== {32'd0, 7'd0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL mid_async got l=%h r=%h lvl=%0d rdy=%b un=%b exp 0 0 0 1 0",
               sample_l, sample_r, level, wr_if.wr_ready, underrun);
    end
    step();
    reset_n = 1;
    while (phase != 6'd62) begin
      step();
      tests++;
      if ({sample_l, sample_r, level, wr_if.wr_ready, underrun} !==
          {m_out_l, m_out_r, 7'(mq.size()), mq.size() != 64, m_underrun}) begin
        fails++;
        $display("FAIL mid_after ph=%0d got l=%h r=%h lvl=%0d un=%b exp l=%h r=%h lvl=%0d un=%b",
                 phase, sample_l, sample_r, level, underrun, m_out_l, m_out_r, mq.size(), m_underrun);
      end
    end
    tests++;
    if ({underrun, level} !== {1'b1, 7'd0}) begin
      fails++;
      $display("FAIL mid_underrun got un=%b lvl=%0d exp 1 0", underrun, level);
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    reset_n = 0; phase = 6'd0;
    wr_if.wr_valid = 0; wr_if.wr_left = 0; wr_if.wr_right = 0;
    vol_l = 9'd256; vol_r = 9'd256; underrun_clr = 0;
    m_stage_l = 0; m_stage_r = 0; m_out_l = 0; m_out_r = 0; m_underrun = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_empty_push61();
    test_volume();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
